sys_cmd_decoder: RTL and testbench
==================================

Name: sys_cmd_decoder

Overview:
Parametrised, next-generation system-controller receive path. It decodes framed command bytes from the UART receiver (Rx_P_Data/RxValid) into register-file writes and reads, and ALU operations. Over the single-frame controller it adds: parametrised width, depth and ALU wait length; burst writes; an inter-byte timeout; error flags; and fully registered register-file address/control outputs. It sits between the UART Rx and the Reg_File/ALU/CLK_Gate.

Parameters:
WIDTH, 8, data and command byte width (≥8).
DEPTH, 16, register-file depth; AW = $clog2(DEPTH).
ALU_WAIT, 2, cycles CLK_GATE_EN is held after ALU_EN (≥1).
TIMEOUT, 255, idle cycles allowed between bytes of one frame before abort (≥2).

Ports:
CLK  in  1  system clock.
Reset  in  1  asynchronous active-low reset.
Rx_P_Data  in  WIDTH  received byte.
RxValid  in  1  one-cycle strobe; Rx_P_Data valid.
ALU_EN  out  1  one-cycle ALU start pulse.
ALU_FUN  out  4  ALU function; low 4 bits of FUN byte.
Reg_File_Adress  out  AW  register-file address, registered.
WrEN  out  1  one-cycle write pulse.
RdEN  out  1  one-cycle read pulse.
WrData  out  WIDTH  write data.
CLK_GATE_EN  out  1  ALU clock-gate enable.
Busy  out  1  high while not in IDLE.
Cmd_Err  out  1  one-cycle pulse; unknown opcode in IDLE.
Timeout_Err  out  1  one-cycle pulse; frame aborted by timeout.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset assertion mid-frame aborts immediately; no partial writes follow.
- Byte acceptance: a byte is accepted only in a cycle where RxValid=1. All registered outputs update on the clock edge that accepts the byte, so they are visible 1 cycle after the RxValid cycle. WrEN, RdEN, ALU_EN, Cmd_Err and Timeout_Err are single-cycle pulses.
- Addresses: an address byte is truncated to its low AW bits.
- States: IDLE, WADDR, WDATA, RADDR, OPA, OPB, FUN, BADDR, BCNT, BDATA, WAIT.
- IDLE transitions on an accepted byte:
  - 0xAA→WADDR, 0xBB→RADDR, 0xCC→OPA, 0xDD→FUN, 0xEE→BADDR.
  - Any other value → Cmd_Err pulse, stay IDLE.
- Single write:
  - WADDR: latch address.
  - WDATA: on accept, WrEN=1, WrData=byte, Reg_File_Adress=latched address; →IDLE.
- Read:
  - RADDR: on accept, Reg_File_Adress=addr, RdEN=1; →IDLE.
- ALU with operands:
  - OPA: write byte to address 0; →OPB.
  - OPB: write byte to address 1; →FUN.
- FUN: on accept, ALU_EN=1, ALU_FUN=byte[3:0]; →WAIT. ALU_FUN holds its value until the next FUN accept or reset.
- WAIT: lasts exactly ALU_WAIT cycles, ignores RxValid, then →IDLE.
- CLK_GATE_EN is decoded from state: 1 in FUN and WAIT, 0 elsewhere. It is therefore high in the ALU_EN cycle and for ALU_WAIT cycles total after the FUN byte.
- Burst write:
  - BADDR: latch start address.
  - BCNT: latch count N (full byte). If N=0 → IDLE with no writes.
  - BDATA: each accepted byte produces WrEN at the current address; the address then increments modulo DEPTH (DEPTH-1 wraps to 0). The remaining count decrements; at 0 → IDLE.
- Timeout:
  - In WADDR, WDATA, RADDR, OPA, OPB, FUN, BADDR, BCNT and BDATA, a counter increments on every cycle without RxValid and clears on RxValid.
  - When it reaches TIMEOUT: Timeout_Err pulse, →IDLE, no output pulses that cycle.
  - The counter is inactive in IDLE and WAIT.
  - If RxValid coincides with the TIMEOUT cycle, the byte wins and no timeout occurs.
- Busy = (state != IDLE), decoded from state.
- WrData: holds its last value when no write occurs.

Optional Feature:
Macro SYS_CMD_BURST_EN.
- Defined: 0xEE burst write supported as above.
- Undefined: BADDR, BCNT and BDATA are not built. 0xEE is treated as an unknown opcode (Cmd_Err pulse, stay IDLE).

Test Plan:
- AA,05,3C → 1 cycle after last RxValid: WrEN=1, Reg_File_Adress=5, WrData=0x3C; Busy low the following cycle.
- BB,07 → RdEN=1 for one cycle with Reg_File_Adress=7; no WrEN.
- CC,12,34,03 → WrEN@addr0 data 0x12, WrEN@addr1 data 0x34, ALU_EN=1 with ALU_FUN=3. CLK_GATE_EN high for ALU_WAIT(2) cycles after FUN; a RxValid=AA during WAIT is ignored.
- EE,0E,03,A1,A2,A3 (DEPTH=16) → writes 0xA1@14, 0xA2@15, 0xA3@0 (wrap), then IDLE. EE,00,00 → no WrEN, back to IDLE. Macro off: EE → Cmd_Err pulse.
- AA,02 then no RxValid for TIMEOUT(255) cycles → Timeout_Err pulse, IDLE. A subsequent BB,02 produces a normal RdEN.
- 0x55 in IDLE → Cmd_Err pulse. Reset asserted between bytes of CC frame → all outputs 0 and no further writes; after release, AA,01,FF works normally.

Source files
------------

// File: rtl/sys_cmd_decoder_if.sv
// Byte-receive and register-file/ALU control bundle for sys_cmd_decoder.
// slave = decoder side, master = UART Rx / downstream side.
interface sys_cmd_decoder_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
);
    logic [WIDTH-1:0] Rx_P_Data;
    logic             RxValid;
    logic             ALU_EN;
    logic [3:0]       ALU_FUN;
    logic [AW-1:0]    Reg_File_Adress;
    logic             WrEN;
    logic             RdEN;
    logic [WIDTH-1:0] WrData;
    logic             CLK_GATE_EN;
    logic             Busy;
    logic             Cmd_Err;
    logic             Timeout_Err;

    modport master (
        output Rx_P_Data, RxValid,
        input  ALU_EN, ALU_FUN, Reg_File_Adress, WrEN, RdEN,
        input  WrData, CLK_GATE_EN, Busy, Cmd_Err, Timeout_Err
    );

    modport slave (
        input  Rx_P_Data, RxValid,
        output ALU_EN, ALU_FUN, Reg_File_Adress, WrEN, RdEN,
        output WrData, CLK_GATE_EN, Busy, Cmd_Err, Timeout_Err
    );
endinterface

// File: rtl/sys_cmd_decoder.sv
// Framed UART command decoder driving Reg_File, ALU and CLK_Gate.
// Define SYS_CMD_BURST_EN to build the 0xEE burst-write frame.
module sys_cmd_decoder #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int ALU_WAIT = 2,
    parameter int TIMEOUT  = 255
) (
    input  logic             CLK,
    input  logic             Reset,
    sys_cmd_decoder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int WW = $clog2(ALU_WAIT + 1);

    localparam logic [WIDTH-1:0] OP_WR = WIDTH'(8'hAA);
    localparam logic [WIDTH-1:0] OP_RD = WIDTH'(8'hBB);
    localparam logic [WIDTH-1:0] OP_OP = WIDTH'(8'hCC);
    localparam logic [WIDTH-1:0] OP_FN = WIDTH'(8'hDD);
`ifdef SYS_CMD_BURST_EN
    localparam logic [WIDTH-1:0] OP_BW = WIDTH'(8'hEE);
`endif

    typedef enum logic [3:0] {
        IDLE, WADDR, WDATA, RADDR, OPA, OPB, FUN, WAIT
`ifdef SYS_CMD_BURST_EN
        , BADDR, BCNT, BDATA
`endif
    } state_t;

    state_t           state;
    logic [AW-1:0]    addr_q;
    logic [TW-1:0]    tcnt;
    logic [WW-1:0]    wcnt;
`ifdef SYS_CMD_BURST_EN
    logic [WIDTH-1:0] cnt_q;
`endif
    logic [WIDTH-1:0] data;
    logic             vld;
    logic             active;
    logic             to_hit;

    assign data   = bus.Rx_P_Data;
    assign vld    = bus.RxValid;
    // Idle-gap counting only while a frame is half received.
    assign active = (state != IDLE) && (state != WAIT);
    assign to_hit = active && !vld && (tcnt == TW'(TIMEOUT - 1));

    assign bus.Busy        = (state != IDLE);
    assign bus.CLK_GATE_EN = (state == FUN) || (state == WAIT);

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state               <= IDLE;
            addr_q              <= '0;
            tcnt                <= '0;
            wcnt                <= '0;
`ifdef SYS_CMD_BURST_EN
            cnt_q               <= '0;
`endif
            bus.ALU_EN          <= 1'b0;
            bus.ALU_FUN         <= '0;
            bus.Reg_File_Adress <= '0;
            bus.WrEN            <= 1'b0;
            bus.RdEN            <= 1'b0;
            bus.WrData          <= '0;
            bus.Cmd_Err         <= 1'b0;
            bus.Timeout_Err     <= 1'b0;
        end else begin
            bus.WrEN        <= 1'b0;
            bus.RdEN        <= 1'b0;
            bus.ALU_EN      <= 1'b0;
            bus.Cmd_Err     <= 1'b0;
            bus.Timeout_Err <= 1'b0;
            tcnt <= (!active || vld || to_hit) ? '0 : tcnt + 1'b1;
            if (to_hit) begin
                bus.Timeout_Err <= 1'b1;
                state           <= IDLE;
            end else begin
                unique case (state)
                    IDLE: if (vld) begin
                        unique case (1'b1)
                            data == OP_WR: state <= WADDR;
                            data == OP_RD: state <= RADDR;
                            data == OP_OP: state <= OPA;
                            data == OP_FN: state <= FUN;
`ifdef SYS_CMD_BURST_EN
                            data == OP_BW: state <= BADDR;
`endif
                            default: bus.Cmd_Err <= 1'b1;
                        endcase
                    end
                    WADDR: if (vld) begin
                        addr_q <= data[AW-1:0];
                        state  <= WDATA;
                    end
                    WDATA: if (vld) begin
                        bus.WrEN            <= 1'b1;
                        bus.WrData          <= data;
                        bus.Reg_File_Adress <= addr_q;
                        state               <= IDLE;
                    end
                    RADDR: if (vld) begin
                        bus.RdEN            <= 1'b1;
                        bus.Reg_File_Adress <= data[AW-1:0];
                        state               <= IDLE;
                    end
                    OPA: if (vld) begin
                        bus.WrEN            <= 1'b1;
                        bus.WrData          <= data;
                        bus.Reg_File_Adress <= '0;
                        state               <= OPB;
                    end
                    OPB: if (vld) begin
                        bus.WrEN            <= 1'b1;
                        bus.WrData          <= data;
                        bus.Reg_File_Adress <= AW'(1);
                        state               <= FUN;
                    end
                    FUN: if (vld) begin
                        bus.ALU_EN  <= 1'b1;
                        bus.ALU_FUN <= data[3:0];
                        wcnt        <= '0;
                        state       <= WAIT;
                    end
                    WAIT: begin
                        if (wcnt == WW'(ALU_WAIT - 1)) begin
                            state <= IDLE;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
`ifdef SYS_CMD_BURST_EN
                    BADDR: if (vld) begin
                        addr_q <= data[AW-1:0];
                        state  <= BCNT;
                    end
                    BCNT: if (vld) begin
                        cnt_q <= data;
                        state <= (data == '0) ? IDLE : BDATA;
                    end
                    // Address wraps at DEPTH, which need not be a power of two.
                    BDATA: if (vld) begin
                        bus.WrEN            <= 1'b1;
                        bus.WrData          <= data;
                        bus.Reg_File_Adress <= addr_q;
                        addr_q <= (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
                        cnt_q  <= cnt_q - 1'b1;
                        if (cnt_q == WIDTH'(1)) begin
                            state <= IDLE;
                        end
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sys_cmd_decoder.sv
// Scoreboard bench for sys_cmd_decoder: frame-level model predicts events,
// a negedge monitor pops and compares them plus per-cycle Busy/gate/hold values.
module tb_sys_cmd_decoder;
    localparam int WIDTH    = 8;
    localparam int DEPTH    = 16;
    localparam int AW       = $clog2(DEPTH);
    localparam int ALU_WAIT = 2;
    localparam int TIMEOUT  = 255;

    typedef enum int {EV_WR, EV_RD, EV_ALU, EV_CERR, EV_TERR} kind_t;
    typedef struct {
        kind_t k;
        int    cyc;
        int    a;
        int    d;
    } ev_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   chk   = 1'b0;
    ev_t  sbq[$];
    bit   busy_map[int];
    bit   gate_map[int];
    int   h_wd   = 0;
    int   h_addr = 0;
    int   h_fun  = 0;
    logic [7:0] fb[$];
    int         fg[$];

    sys_cmd_decoder_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    sys_cmd_decoder #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ALU_WAIT(ALU_WAIT), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(clk),
        .Reset(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk(kind_t k, int c, int a, int d);
        ev_t e;
        e.k = k; e.cyc = c; e.a = a; e.d = d;
        return e;
    endfunction

    function automatic void check(string nm, int act, int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) cycle %0d",
                     nm, act, act, req, req, cyc);
        end
    endfunction

    always @(negedge clk) begin
        ev_t o[$];
        ev_t e;
        if (chk) begin
            o.delete();
            if (bus.WrEN)
                o.push_back(mk(EV_WR, cyc, int'(bus.Reg_File_Adress), int'(bus.WrData)));
            if (bus.RdEN)
                o.push_back(mk(EV_RD, cyc, int'(bus.Reg_File_Adress), 0));
            if (bus.ALU_EN)
                o.push_back(mk(EV_ALU, cyc, int'(bus.ALU_FUN), 0));
            if (bus.Cmd_Err)
                o.push_back(mk(EV_CERR, cyc, 0, 0));
            if (bus.Timeout_Err)
                o.push_back(mk(EV_TERR, cyc, 0, 0));
            while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                e = sbq.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL missed_event: kind %0d due cycle %0d not seen by %0d",
                         e.k, e.cyc, cyc);
            end
            foreach (o[i]) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_event: kind %0d at cycle %0d, none expected",
                             o[i].k, cyc);
                end else begin
                    e = sbq.pop_front();
                    check("ev_kind", int'(o[i].k), int'(e.k));
                    check("ev_cycle", o[i].cyc, e.cyc);
                    check("ev_addr", o[i].a, e.a);
                    check("ev_data", o[i].d, e.d);
                    if (e.k == EV_WR) begin h_wd = e.d; h_addr = e.a; end
                    if (e.k == EV_RD) h_addr = e.a;
                    if (e.k == EV_ALU) h_fun = e.a;
                end
            end
            check("busy", int'(bus.Busy), int'(busy_map.exists(cyc)));
            check("clk_gate_en", int'(bus.CLK_GATE_EN), int'(gate_map.exists(cyc)));
            check("wrdata_hold", int'(bus.WrData), h_wd);
            check("addr_hold", int'(bus.Reg_File_Adress), h_addr);
            check("alu_fun_hold", int'(bus.ALU_FUN), h_fun);
            busy_map.delete(cyc);
            gate_map.delete(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        bus.RxValid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send(input logic [7:0] b);
        bus.Rx_P_Data = b;
        bus.RxValid   = 1'b1;
        step();
    endtask

    task automatic chk_zero();
        check("rst_alu_en", int'(bus.ALU_EN), 0);
        check("rst_alu_fun", int'(bus.ALU_FUN), 0);
        check("rst_addr", int'(bus.Reg_File_Adress), 0);
        check("rst_wren", int'(bus.WrEN), 0);
        check("rst_rden", int'(bus.RdEN), 0);
        check("rst_wrdata", int'(bus.WrData), 0);
        check("rst_gate", int'(bus.CLK_GATE_EN), 0);
        check("rst_busy", int'(bus.Busy), 0);
        check("rst_cmd_err", int'(bus.Cmd_Err), 0);
        check("rst_to_err", int'(bus.Timeout_Err), 0);
    endtask

    // g[i] = idle cycles before byte i; a gap of TIMEOUT or more aborts the frame.
    task automatic run_frame(input logic [7:0] b[$], input int g[$], input bit ign);
        int t[$];
        int op, len, nsend, endc, gs, base;
        bit known, abort, alu;
        op = int'(b[0]);
        len = 1; known = 1'b1; alu = 1'b0; gs = -1;
        if (op == 'hAA) len = 3;
        else if (op == 'hBB) len = 2;
        else if (op == 'hCC) begin len = 4; alu = 1'b1; end
        else if (op == 'hDD) begin len = 2; alu = 1'b1; end
`ifdef SYS_CMD_BURST_EN
        else if (op == 'hEE) len = 3 + int'(b[2]);
`endif
        else known = 1'b0;
        nsend = len;
        abort = 1'b0;
        for (int i = 1; i < len; i++)
            if (!abort && g[i] >= TIMEOUT) begin abort = 1'b1; nsend = i; end
        t.push_back(cyc + g[0]);
        for (int i = 1; i < nsend; i++) t.push_back(t[i-1] + 1 + g[i]);
        if (!known) begin
            sbq.push_back(mk(EV_CERR, t[0] + 1, 0, 0));
        end else begin
            case (op)
                'hAA: if (nsend == 3)
                    sbq.push_back(mk(EV_WR, t[2] + 1, int'(b[1]) % (1 << AW), int'(b[2])));
                'hBB: if (nsend == 2)
                    sbq.push_back(mk(EV_RD, t[1] + 1, int'(b[1]) % (1 << AW), 0));
                'hCC: begin
                    if (nsend > 1) sbq.push_back(mk(EV_WR, t[1] + 1, 0, int'(b[1])));
                    if (nsend > 2) sbq.push_back(mk(EV_WR, t[2] + 1, 1, int'(b[2])));
                    if (nsend > 3) sbq.push_back(mk(EV_ALU, t[3] + 1, int'(b[3]) % 16, 0));
                    if (nsend > 2) gs = t[2] + 1;
                end
                'hDD: begin
                    if (nsend > 1) sbq.push_back(mk(EV_ALU, t[1] + 1, int'(b[1]) % 16, 0));
                    gs = t[0] + 1;
                end
                default: begin
                    base = int'(b[1]) % (1 << AW);
                    for (int j = 3; j < nsend; j++)
                        sbq.push_back(mk(EV_WR, t[j] + 1, (base + j - 3) % DEPTH, int'(b[j])));
                end
            endcase
            if (abort) begin
                endc = t[nsend-1] + TIMEOUT;
                sbq.push_back(mk(EV_TERR, endc + 1, 0, 0));
            end else begin
                endc = t[len-1] + (alu ? ALU_WAIT : 0);
            end
            for (int c = t[0] + 1; c <= endc; c++) busy_map[c] = 1'b1;
            if (gs >= 0)
                for (int c = gs; c <= endc; c++) gate_map[c] = 1'b1;
        end
        for (int i = 0; i < nsend; i++) begin
            idle(g[i]);
            send(b[i]);
        end
        if (abort) idle(g[nsend]);
        else if (ign && alu && known) send(8'hAA);
        idle(ALU_WAIT + 3);
    endtask

    task automatic rand_frame();
        logic [7:0] b[$];
        int g[$];
        int sel, v, n;
        sel = $urandom_range(0, 5);
        b.push_back(8'h00);
        case (sel)
            0: begin b[0] = 8'hAA; n = 2; end
            1: begin b[0] = 8'hBB; n = 1; end
            2: begin b[0] = 8'hCC; n = 3; end
            3: begin b[0] = 8'hDD; n = 1; end
            4: begin
                b[0] = 8'hEE;
`ifdef SYS_CMD_BURST_EN
                b.push_back(8'($urandom_range(0, 255)));
                b.push_back(8'($urandom_range(0, 4)));
                n = int'(b[2]);
`else
                n = 0;
`endif
            end
            default: begin
                do begin
                    v = $urandom_range(0, 255);
                end while (v == 'hAA || v == 'hBB || v == 'hCC || v == 'hDD
`ifdef SYS_CMD_BURST_EN
                           || v == 'hEE
`endif
                          );
                b[0] = 8'(v);
                n = 0;
            end
        endcase
        for (int i = 0; i < n; i++) b.push_back(8'($urandom_range(0, 255)));
        foreach (b[i]) g.push_back($urandom_range(0, 3));
        if (b.size() > 1 && $urandom_range(0, 5) == 0) begin
            v = $urandom_range(1, b.size() - 1);
            g[v] = ($urandom_range(0, 1) == 1) ? TIMEOUT : TIMEOUT - 1;
        end
        run_frame(b, g, 1'($urandom_range(0, 1)));
    endtask

    initial begin
        bus.Rx_P_Data = '0;
        bus.RxValid   = 1'b0;
        rst_n = 1'b0;
        idle(3);
        chk_zero();
        rst_n = 1'b1;
        chk = 1'b1;
        idle(2);

        fb = '{8'hAA, 8'h05, 8'h3C}; fg = '{0, 1, 0};
        run_frame(fb, fg, 1'b0);
        fb = '{8'hBB, 8'h07}; fg = '{0, 0};
        run_frame(fb, fg, 1'b0);
        fb = '{8'hCC, 8'h12, 8'h34, 8'h03}; fg = '{0, 0, 2, 0};
        run_frame(fb, fg, 1'b1);
`ifdef SYS_CMD_BURST_EN
        fb = '{8'hEE, 8'h0E, 8'h03, 8'hA1, 8'hA2, 8'hA3}; fg = '{0, 0, 0, 1, 0, 0};
        run_frame(fb, fg, 1'b0);
        fb = '{8'hEE, 8'h00, 8'h00}; fg = '{0, 0, 0};
        run_frame(fb, fg, 1'b0);
`else
        fb = '{8'hEE}; fg = '{0};
        run_frame(fb, fg, 1'b0);
`endif
        fb = '{8'hAA, 8'h02, 8'h00}; fg = '{0, 0, TIMEOUT};
        run_frame(fb, fg, 1'b0);
        fb = '{8'hBB, 8'h02}; fg = '{0, 0};
        run_frame(fb, fg, 1'b0);
        fb = '{8'hAA, 8'h13, 8'h77}; fg = '{0, TIMEOUT - 1, TIMEOUT - 1};
        run_frame(fb, fg, 1'b0);
        fb = '{8'hDD, 8'h0A}; fg = '{1, TIMEOUT};
        run_frame(fb, fg, 1'b0);
        fb = '{8'h55}; fg = '{0};
        run_frame(fb, fg, 1'b0);
        fb = '{8'hDD, 8'hF9}; fg = '{0, 3};
        run_frame(fb, fg, 1'b1);

        chk = 1'b0;
        send(8'hCC);
        send(8'h12);
        #2 rst_n = 1'b0;
        #1 chk_zero();
        send(8'h34);
        idle(2);
        chk_zero();
        sbq.delete();
        busy_map.delete();
        gate_map.delete();
        h_wd = 0; h_addr = 0; h_fun = 0;
        rst_n = 1'b1;
        chk = 1'b1;
        idle(4);
        fb = '{8'hAA, 8'h01, 8'hFF}; fg = '{0, 0, 0};
        run_frame(fb, fg, 1'b0);

        for (int f = 0; f < 40; f++) rand_frame();

        idle(5);
        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d events left, expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
